// File: rtl/alu_mc_if.sv
// alu_mc_if: start/done request bus between the control unit and the
// multi-cycle ALU. The master issues operations; the slave (ALU) returns
// the registered result and flags.
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [3:0]       ctrl_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic             ready_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;
    logic             cout_o;
    logic             overflow_o;

    modport master (
        output start_i, ctrl_i, src1_i, src2_i,
        input  ready_o, done_o, result_o, zero_o, cout_o, overflow_o
    );

    modport slave (
        input  start_i, ctrl_i, src1_i, src2_i,
        output ready_o, done_o, result_o, zero_o, cout_o, overflow_o
    );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: WIDTH-bit multi-cycle ALU with registered result and flags.
// AND/OR/ADD/SUB/SLT/NOR complete one edge after acceptance. The optional
// shift-add multiplier (ctrl 1000) is built only when ALU_MC_MUL_EN is
// defined; otherwise 1000 behaves as an illegal code.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input logic     clk_i,
    input logic     rst_i,
    alu_mc_if.slave bus
);
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
`ifdef ALU_MC_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam int         CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;
`else
    typedef enum logic [0:0] {IDLE, EXEC} state_t;
`endif

    state_t           state_q, state_d;
    logic             load, write_exec, write_mul;
    logic [3:0]       ctrl_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] result_q;
    logic             cout_q, ovf_q, done_q;

    // Adder: ripple generalisation, with the carry into the MSB kept separate
    // so signed overflow is carry-in XOR carry-out of the top bit.
    logic             sub_mode, cin;
    logic [WIDTH-1:0] b_eff, low, sum;
    logic [1:0]       msb;
    logic             c_msb, add_cout, add_ovf;

    assign sub_mode = (ctrl_q == OP_SUB) || (ctrl_q == OP_SLT);
    assign cin      = sub_mode;
    assign b_eff    = sub_mode ? ~b_q : b_q;
    assign low      = {1'b0, a_q[WIDTH-2:0]} + {1'b0, b_eff[WIDTH-2:0]}
                    + {{(WIDTH-1){1'b0}}, cin};
    assign c_msb    = low[WIDTH-1];
    assign msb      = {1'b0, a_q[WIDTH-1]} + {1'b0, b_eff[WIDTH-1]} + {1'b0, c_msb};
    assign sum      = {msb[0], low[WIDTH-2:0]};
    assign add_cout = msb[1];
    assign add_ovf  = c_msb ^ add_cout;

    logic [WIDTH-1:0] exec_res;
    logic             exec_cout, exec_ovf;

    // Single-cycle result and flag selection for the EXEC state.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned and no latch is inferred.
        exec_res  = '0;
        exec_cout = 1'b0;
        exec_ovf  = 1'b0;
        case (ctrl_q)
            OP_AND: exec_res = a_q & b_q;
            OP_OR:  exec_res = a_q | b_q;
            OP_NOR: exec_res = ~(a_q | b_q);
            OP_ADD, OP_SUB: begin
                exec_res  = sum;
                exec_cout = add_cout;
                exec_ovf  = add_ovf;
            end
            OP_SLT: exec_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
            default: ;
        endcase
    end

`ifdef ALU_MC_MUL_EN
    // Shift-add multiplier: the upper half holds the partial sum, the lower
    // half the remaining multiplier bits, consumed LSB first.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]     partial;
    logic [CW-1:0]      cnt_q;

    assign partial = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    assign acc_d   = {partial, acc_q[WIDTH-1:1]};

    // Accumulator and down-counter for the MUL iterations.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            acc_q <= {{WIDTH{1'b0}}, bus.src2_i};
            cnt_q <= CW'(WIDTH - 1);
        end else if (state_q == MUL) begin
            acc_q <= acc_d;
            if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
        end
    end
`endif

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic and datapath strobes.
    always_comb begin
        state_d    = state_q;
        load       = 1'b0;
        write_exec = 1'b0;
        write_mul  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    load    = 1'b1;
                    state_d = EXEC;
`ifdef ALU_MC_MUL_EN
                    if (bus.ctrl_i == OP_MUL) state_d = MUL;
`endif
                end
            end
            EXEC: begin
                write_exec = 1'b1;
                state_d    = IDLE;
            end
`ifdef ALU_MC_MUL_EN
            MUL: begin
                if (cnt_q == '0) begin
                    write_mul = 1'b1;
                    state_d   = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Operand and opcode copies, taken when a request is accepted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl_q <= '0;
            a_q    <= '0;
            b_q    <= '0;
        end else if (load) begin
            ctrl_q <= bus.ctrl_i;
            a_q    <= bus.src1_i;
            b_q    <= bus.src2_i;
        end
    end

    // Registered result, flags and one-cycle done pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (write_exec) begin
                result_q <= exec_res;
                cout_q   <= exec_cout;
                ovf_q    <= exec_ovf;
                done_q   <= 1'b1;
            end
`ifdef ALU_MC_MUL_EN
            if (write_mul) begin
                result_q <= acc_d[WIDTH-1:0];
                cout_q   <= |acc_d[2*WIDTH-1:WIDTH];
                ovf_q    <= 1'b0;
                done_q   <= 1'b1;
            end
`endif
        end
    end

    assign bus.ready_o    = (state_q == IDLE);
    assign bus.done_o     = done_q;
    assign bus.result_o   = result_q;
    assign bus.zero_o     = (result_q == '0);
    assign bus.cout_o     = cout_q;
    assign bus.overflow_o = ovf_q;

`ifndef ALU_MC_MUL_EN
    // Without the multiplier the MUL-done strobe has no consumer.
    logic unused_write_mul;
    assign unused_write_mul = write_mul;
`endif
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: randomized self-checking bench for alu_mc against an
// arithmetic reference model. Follows ALU_MC_MUL_EN for the expected
// behaviour of ctrl 1000.
module tb_alu_mc;
    localparam int W = 32;
`ifdef ALU_MC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_mc_if #(.WIDTH(W)) bus ();
    alu_mc #(.WIDTH(W)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: plain arithmetic on the operands.
    function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic c, output logic v,
                                  output int lat);
        logic [W:0]     s;
        logic [2*W-1:0] aw, bw, p;
        r = '0; c = 1'b0; v = 1'b0; lat = 1;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b1100: r = ~(a | b);
            4'b0010: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[W-1:0];
                c = s[W];
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            4'b0110: begin
                s = {1'b0, a} - {1'b0, b};
                r = s[W-1:0];
                c = (a >= b);
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            4'b0111: r = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            4'b1000: begin
                if (MUL_EN) begin
                    aw  = {{W{1'b0}}, a};
                    bw  = {{W{1'b0}}, b};
                    p   = aw * bw;
                    r   = p[W-1:0];
                    c   = (p[2*W-1:W] != '0);
                    lat = W;
                end
            end
            default: ;
        endcase
    endfunction

    // Issue one op (caller sits just after a rising edge with ready_o high),
    // wait for done_o, then compare. Leaves time in the done_o cycle.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit noise);
        logic [W-1:0] er;
        logic         ec, ev;
        int           elat, cyc;
        model(op, a, b, er, ec, ev, elat);
        check($sformatf("ready_idle op%0h", op), bus.ready_o, 1);
        bus.start_i = 1'b1;
        bus.ctrl_i  = op;
        bus.src1_i  = a;
        bus.src2_i  = b;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        bus.src1_i  = $urandom;
        bus.src2_i  = $urandom;
        bus.ctrl_i  = 4'($urandom);
        cyc = 0;
        do begin
            check($sformatf("ready_busy op%0h", op), bus.ready_o, 0);
            if (noise) begin
                bus.start_i = 1'($urandom_range(0, 1));
                bus.ctrl_i  = 4'($urandom);
            end
            @(posedge clk); #1;
            cyc++;
            bus.start_i = 1'b0;
        end while (!bus.done_o && cyc < W + 8);
        check($sformatf("latency op%0h", op), 64'(cyc), 64'(elat));
        check($sformatf("done op%0h", op), bus.done_o, 1);
        check($sformatf("result op%0h a=%0h b=%0h", op, a, b), bus.result_o, er);
        check($sformatf("zero op%0h", op), bus.zero_o, (er == '0));
        check($sformatf("cout op%0h", op), bus.cout_o, ec);
        check($sformatf("ovf op%0h", op), bus.overflow_o, ev);
        check($sformatf("ready_done op%0h", op), bus.ready_o, 1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            check("done_single_pulse", bus.done_o, 0);
        end
    endtask

    // Assert reset between edges and check outputs before any clock edge.
    task automatic do_reset();
        bus.start_i = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_ready", bus.ready_o, 1);
        check("rst_done", bus.done_o, 0);
        check("rst_result", bus.result_o, 0);
        check("rst_zero", bus.zero_o, 1);
        check("rst_cout", bus.cout_o, 0);
        check("rst_ovf", bus.overflow_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    logic [3:0]   ops [8]     = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1000, 4'b1111};
    logic [W-1:0] corners [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

    initial begin
        logic [3:0]   op;
        logic [W-1:0] a, b;
        int           n_done;

        rst = 1'b0;
        bus.start_i = 1'b0;
        bus.ctrl_i  = '0;
        bus.src1_i  = '0;
        bus.src2_i  = '0;
        #1;
        do_reset();

        // Directed corner cases.
        run_op(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        idle_cycles(1);
        run_op(4'b0110, 32'd5, 32'd5, 1'b0);
        idle_cycles(1);
        run_op(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        run_op(4'b0111, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
        run_op(4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
        run_op(4'b1000, 32'h0001_0000, 32'h0001_0000, 1'b1);
        idle_cycles(1);
        run_op(4'b1000, 32'd7, 32'd6, 1'b1);
        idle_cycles(1);
        // Back-to-back: the second op is issued in the first op's done cycle.
        run_op(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
        run_op(4'b1100, 32'h0, 32'h0, 1'b0);
        idle_cycles(1);
        run_op(4'b1111, 32'd3, 32'd4, 1'b0);
        idle_cycles(1);

        // Randomized ops with a bias toward corner operands.
        for (int i = 0; i < 60; i++) begin
            op = ops[$urandom_range(0, 7)];
            if ($urandom_range(0, 7) == 0) op = 4'($urandom);
            a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
            b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
            run_op(op, a, b, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle_cycles(1);
        end

        // Reset mid-operation: no done_o may follow for the aborted op.
        run_op(4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        bus.start_i = 1'b1;
        bus.ctrl_i  = MUL_EN ? 4'b1000 : 4'b0010;
        bus.src1_i  = 32'd3;
        bus.src2_i  = 32'd5;
        if (MUL_EN) begin
            @(posedge clk); #1;
            bus.start_i = 1'b0;
            repeat (9) @(posedge clk);
            #1;
        end
        do_reset();
        n_done = 0;
        repeat (W + 4) begin
            @(posedge clk); #1;
            if (bus.done_o) n_done++;
        end
        check("abort_no_done", 64'(n_done), 0);
        run_op(4'b0010, 32'd2, 32'd3, 1'b0);
        idle_cycles(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
